// File: rtl/uart_tx_if.sv
// Host/serializer-side signal bundle for the UART transmit frame sequencer.
// The master modport is the host/datapath side; slave is the sequencer itself.
interface uart_tx_if;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_done;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       par_bit;
  logic       busy;
  logic       frame_err;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_done,
    input  ser_en, mux_sel, par_bit, busy, frame_err
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_done,
    output ser_en, mux_sel, par_bit, busy, frame_err
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, 8 data bits, optional parity, stop.
// Define UART_TX_STOP2_EN to append a second stop bit to every frame.
module uart_tx_ctrl (
  input  logic       CLK,
  input  logic       RST,
  uart_tx_if.slave   tx
);

`ifdef UART_TX_STOP2_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`endif

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_STOP   = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;
  // The counter holds DATA cycles already completed, so 14 marks the 15th.
  localparam logic [3:0] TMO_LAST   = 4'd14;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       err_q;
  logic [7:0] data_q;
  logic       par_en_q;
  logic       par_typ_q;
  logic       accept;
  logic       tmo;

  function automatic logic calc_parity(input logic [7:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  assign tmo = (state_q == S_DATA) && !tx.ser_done && (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx.DATA_VALID) begin
          accept  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: state_d = S_DATA;
      S_DATA: begin
        if (tx.ser_done)
          state_d = par_en_q ? S_PARITY : S_STOP;
        else if (cnt_q == TMO_LAST)
          state_d = S_STOP;
      end
      S_PARITY: state_d = S_STOP;
`ifdef UART_TX_STOP2_EN
      S_STOP: state_d = S_STOP2;
      S_STOP2: begin
        if (tx.DATA_VALID) begin
          accept  = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
`else
      S_STOP: begin
        if (tx.DATA_VALID) begin
          accept  = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      data_q    <= 8'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_DATA) ? cnt_q + 4'd1 : 4'd0;
      err_q   <= tmo;
      if (accept) begin
        data_q    <= tx.P_DATA;
        par_en_q  <= tx.PAR_EN;
        par_typ_q <= tx.PAR_TYP;
      end
    end
  end

  // Moore outputs: decoded from registered state only.
  always_comb begin
    tx.ser_en  = 1'b0;
    tx.mux_sel = MUX_STOP;
    tx.busy    = 1'b1;
    case (state_q)
      S_IDLE:   tx.busy = 1'b0;
      S_START: begin
        tx.mux_sel = MUX_START;
        tx.ser_en  = 1'b1;
      end
      S_DATA: begin
        tx.mux_sel = MUX_DATA;
        tx.ser_en  = 1'b1;
      end
      S_PARITY: tx.mux_sel = MUX_PARITY;
      default:  tx.mux_sel = MUX_STOP;
    endcase
  end

  assign tx.frame_err = err_q;
  assign tx.par_bit   = calc_parity(data_q, par_typ_q);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized self-checking bench for uart_tx_ctrl against a frame-level model.
module tb_uart_tx_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  uart_tx_if tx_if ();
  uart_tx_ctrl dut (.CLK(CLK), .RST(RST), .tx(tx_if));

  always #5 CLK = ~CLK;

  function automatic bit ref_parity(input logic [7:0] d, input bit odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return ((ones % 2) == 1) ^ odd;
  endfunction

  // Caller has driven DATA_VALID=1 and the frame's inputs; the next edge accepts.
  task automatic run_frame(input string tag, input logic [7:0] d, input bit pe,
                           input bit pt, input int done_at, input bit junk,
                           input bit chain, input logic [7:0] nd, input bit npe,
                           input bit npt);
    int  exp_mux[$];
    int  n_data, k, m, err_idx;
    bit  tmo, ep, par_cycle;
    ep        = ref_parity(d, pt);
    tmo       = (done_at < 1) || (done_at > 15);
    n_data    = tmo ? 15 : done_at;
    par_cycle = pe && !tmo;
    exp_mux.push_back(0);
    for (int i = 0; i < n_data; i++) exp_mux.push_back(2);
    if (par_cycle) exp_mux.push_back(3);
    for (int i = 0; i < NSTOP; i++) exp_mux.push_back(1);
    err_idx = tmo ? 1 + n_data : -1;
    k = 0;
    for (int i = 0; i < exp_mux.size(); i++) begin
      m = exp_mux[i];
      @(posedge CLK); #1;
      checks++;
      if (tx_if.mux_sel !== 2'(m)) begin
        errors++;
        $display("FAIL %s mux_sel cyc%0d got %0d want %0d", tag, i, tx_if.mux_sel, m);
      end
      checks++;
      if (tx_if.ser_en !== ((m == 0) || (m == 2))) begin
        errors++;
        $display("FAIL %s ser_en cyc%0d got %0b want %0b", tag, i, tx_if.ser_en, (m == 0) || (m == 2));
      end
      checks++;
      if (tx_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cyc%0d got %0b want 1", tag, i, tx_if.busy);
      end
      checks++;
      if (tx_if.frame_err !== (i == err_idx)) begin
        errors++;
        $display("FAIL %s frame_err cyc%0d got %0b want %0b", tag, i, tx_if.frame_err, i == err_idx);
      end
      checks++;
      if (tx_if.par_bit !== ep) begin
        errors++;
        $display("FAIL %s par_bit cyc%0d got %0b want %0b", tag, i, tx_if.par_bit, ep);
      end
      if (m == 2) begin
        k++;
        tx_if.ser_done = (k == done_at);
      end else begin
        tx_if.ser_done = 1'($urandom);
      end
      if (i == exp_mux.size() - 1) begin
        tx_if.DATA_VALID = chain;
        if (chain) begin
          tx_if.P_DATA  = nd;
          tx_if.PAR_EN  = npe;
          tx_if.PAR_TYP = npt;
        end
      end else begin
        tx_if.DATA_VALID = (m == 1) ? 1'b1 : (junk ? 1'($urandom) : 1'b0);
        if (junk) begin
          tx_if.P_DATA  = 8'($urandom);
          tx_if.PAR_EN  = 1'($urandom);
          tx_if.PAR_TYP = 1'($urandom);
        end
      end
    end
    if (!chain) begin
      @(posedge CLK); #1;
      checks++;
      if (tx_if.mux_sel !== 2'b01 || tx_if.busy !== 1'b0 || tx_if.ser_en !== 1'b0 ||
          tx_if.frame_err !== 1'b0) begin
        errors++;
        $display("FAIL %s idle_after got mux=%0d busy=%0b en=%0b err=%0b want mux=1 busy=0 en=0 err=0",
                 tag, tx_if.mux_sel, tx_if.busy, tx_if.ser_en, tx_if.frame_err);
      end
      checks++;
      if (tx_if.par_bit !== ep) begin
        errors++;
        $display("FAIL %s par_hold got %0b want %0b", tag, tx_if.par_bit, ep);
      end
    end
  endtask

  task automatic request(input logic [7:0] d, input bit pe, input bit pt);
    tx_if.P_DATA     = d;
    tx_if.PAR_EN     = pe;
    tx_if.PAR_TYP    = pt;
    tx_if.DATA_VALID = 1'b1;
  endtask

  task automatic check_idle_reset(input string tag);
    checks++;
    if (tx_if.mux_sel !== 2'b01 || tx_if.ser_en !== 1'b0 || tx_if.busy !== 1'b0 ||
        tx_if.frame_err !== 1'b0 || tx_if.par_bit !== 1'b0) begin
      errors++;
      $display("FAIL %s got mux=%0d en=%0b busy=%0b err=%0b par=%0b want mux=1 en=0 busy=0 err=0 par=0",
               tag, tx_if.mux_sel, tx_if.ser_en, tx_if.busy, tx_if.frame_err, tx_if.par_bit);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tx_if.DATA_VALID = 1'b0;
    tx_if.ser_done   = 1'b0;
    tx_if.P_DATA     = 8'h00;
    tx_if.PAR_EN     = 1'b0;
    tx_if.PAR_TYP    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_idle_reset("reset_initial");
    RST = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    request(8'h01, 1'b1, 1'b0);
    @(posedge CLK); #1;
    tx_if.DATA_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (tx_if.mux_sel !== 2'b10 || tx_if.par_bit !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre mux=%0d par=%0b want mux=2 par=1", tx_if.mux_sel, tx_if.par_bit);
    end
    RST = 1'b1;
    tx_if.ser_done = 1'b1;
    tx_if.DATA_VALID = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_idle_reset("reset_mid_frame");
    RST = 1'b0;
    tx_if.DATA_VALID = 1'b0;
    tx_if.ser_done = 1'b0;
    @(posedge CLK); #1;
    check_idle_reset("reset_release");
  endtask

  task automatic test_parity();
    request(8'hA5, 1'b1, 1'b0);
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    request(8'h07, 1'b1, 1'b1);
    run_frame("07_odd", 8'h07, 1'b1, 1'b1, 8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    request(8'h03, 1'b1, 1'b1);
    run_frame("03_odd", 8'h03, 1'b1, 1'b1, 8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    request(8'h03, 1'b0, 1'b1);
    run_frame("no_par", 8'h03, 1'b0, 1'b1, 8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    request(8'h55, 1'b1, 1'b0);
    run_frame("b2b_55", 8'h55, 1'b1, 1'b0, 8, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
    run_frame("b2b_aa", 8'hAA, 1'b1, 1'b1, 8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    request(8'h81, 1'b1, 1'b0);
    run_frame("timeout", 8'h81, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    request(8'h3C, 1'b1, 1'b1);
    run_frame("done_at_15", 8'h3C, 1'b1, 1'b1, 15, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_stop_bits();
    request(8'hFF, 1'b1, 1'b0);
    run_frame("ff_stop", 8'hFF, 1'b1, 1'b0, 8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] d, nd;
    bit pe, pt, npe, npt, chain, prev_chain;
    int done_at;
    d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
    prev_chain = 1'b0;
    for (int f = 0; f < 30; f++) begin
      if (!prev_chain) request(d, pe, pt);
      nd = 8'($urandom); npe = 1'($urandom); npt = 1'($urandom);
      chain = 1'($urandom);
      done_at = $urandom_range(1, 16);
      run_frame("random", d, pe, pt, done_at, 1'b1, chain, nd, npe, npt);
      d = nd; pe = npe; pt = npt;
      prev_chain = chain;
    end
    if (prev_chain) begin
      run_frame("random_tail", d, pe, pt, 8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_parity();
    test_back_to_back();
    test_timeout();
    test_stop_bits();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
